// File: rtl/shift_left_piso_tx.sv
// shift_left_piso_tx: parallel-in serial-out transmitter, MSB first.
// Feeds a left-shift SIPO clocked on the same edges. A load/ready handshake
// with a done pulse on the last bit lets words stream back-to-back.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to each
// frame, computed from the captured word.
module shift_left_piso_tx #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] parallel_data_in,
   input  logic             load,
   output logic             ready,
   output logic             serial_data_out,
   output logic             serial_valid,
   output logic             done,
   output logic             busy
);

`ifdef PISO_PARITY_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif
   localparam int CW = $clog2(FLEN + 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [FLEN-1:0] shift_q;
   logic [FLEN-1:0] shift_d;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic [FLEN-1:0] load_word;
   logic            last_bit;
   logic            accept;

   // Frame image loaded into the shift register; the parity bit trails data[0].
   always_comb begin
`ifdef PISO_PARITY_EN
      load_word = {parallel_data_in, ^parallel_data_in};
`else
      load_word = parallel_data_in;
`endif
   end

   // Outputs are decoded from registered state only, never from load or data.
   always_comb begin
      last_bit        = (state_q == SHIFT) && (cnt_q == CW'(1));
      serial_valid    = (state_q == SHIFT);
      busy            = (state_q == SHIFT);
      done            = last_bit;
      ready           = (state_q == IDLE) || last_bit;
      serial_data_out = (state_q == SHIFT) && shift_q[FLEN-1];
      accept          = load && ready;
   end

   // Next-state logic: capture on an accepted load, otherwise shift and count down.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d = load_word;
               cnt_d   = CW'(FLEN);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit && accept) begin
               shift_d = load_word;
               cnt_d   = CW'(FLEN);
               state_d = SHIFT;
            end else begin
               shift_d = {shift_q[FLEN-2:0], 1'b0};
               cnt_d   = cnt_q - CW'(1);
               if (last_bit) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // State register; reset aborts any frame in flight and wins over load.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_shift_left_piso_tx.sv
// Directed testbench for shift_left_piso_tx (WIDTH=4). Expected serial
// streams are written out by hand for both the plain and the parity build.
module tb_shift_left_piso_tx;

   localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif

   logic             clk;
   logic             reset;
   logic [WIDTH-1:0] parallel_data_in;
   logic             load;
   logic             ready;
   logic             serial_data_out;
   logic             serial_valid;
   logic             done;
   logic             busy;
   logic [4:0]       obs;

   int errors = 0;
   int checks = 0;

   shift_left_piso_tx #(.WIDTH(WIDTH)) dut (
      .clk              (clk),
      .reset            (reset),
      .parallel_data_in (parallel_data_in),
      .load             (load),
      .ready            (ready),
      .serial_data_out  (serial_data_out),
      .serial_valid     (serial_valid),
      .done             (done),
      .busy             (busy)
   );

   // Observed outputs packed as {serial_data_out, serial_valid, done, busy, ready}.
   assign obs = {serial_data_out, serial_valid, done, busy, ready};

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic test_reset();
      reset = 1'b1;
      load = 1'b1;
      parallel_data_in = 4'b1111;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 5'b00001);
      end
      reset = 1'b0;
      load = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL post_reset_idle: got %b expected %b", obs, 5'b00001);
      end
   endtask

   task automatic test_single_frame();
      logic [FLEN-1:0]  bits;
      logic [WIDTH-1:0] sipo;
      logic [4:0]       exp;
`ifdef PISO_PARITY_EN
      bits = 5'b11011;
`else
      bits = 4'b1101;
`endif
      sipo = '0;
      load = 1'b1;
      parallel_data_in = 4'b1101;
      for (int i = 0; i < FLEN; i++) begin
         @(negedge clk);
         load = 1'b0;
         parallel_data_in = 4'b0000;
         exp = {bits[FLEN-1-i], 1'b1, (i == FLEN-1), 1'b1, (i == FLEN-1)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL single_bit%0d: got %b expected %b", i, obs, exp);
         end
         if (i < WIDTH) sipo = {sipo[WIDTH-2:0], serial_data_out};
      end
      checks++;
      if (sipo !== 4'b1101) begin
         errors++;
         $display("[TB] FAIL sipo_capture: got %b expected %b", sipo, 4'b1101);
      end
      @(negedge clk);
      checks++;
      if (obs !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL single_idle: got %b expected %b", obs, 5'b00001);
      end
   endtask

   task automatic test_back_to_back();
      logic [2*FLEN-1:0] stream;
      logic [4:0]        exp;
      logic              last;
`ifdef PISO_PARITY_EN
      stream = 10'b10100_01100;
`else
      stream = 8'b1010_0110;
`endif
      load = 1'b1;
      parallel_data_in = 4'b1010;
      for (int i = 0; i < 2*FLEN; i++) begin
         @(negedge clk);
         if (i == 0) parallel_data_in = 4'b0110;
         if (i == FLEN) load = 1'b0;
         last = (i == FLEN-1) || (i == 2*FLEN-1);
         exp = {stream[2*FLEN-1-i], 1'b1, last, 1'b1, last};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL b2b_bit%0d: got %b expected %b", i, obs, exp);
         end
      end
      @(negedge clk);
      checks++;
      if (obs !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL b2b_idle: got %b expected %b", obs, 5'b00001);
      end
   endtask

   task automatic test_ignored_load();
      logic [FLEN-1:0] bits;
      logic [4:0]      exp;
`ifdef PISO_PARITY_EN
      bits = 5'b10010;
`else
      bits = 4'b1001;
`endif
      load = 1'b1;
      parallel_data_in = 4'b1001;
      for (int i = 0; i < FLEN; i++) begin
         @(negedge clk);
         exp = {bits[FLEN-1-i], 1'b1, (i == FLEN-1), 1'b1, (i == FLEN-1)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL ignored_bit%0d: got %b expected %b", i, obs, exp);
         end
         load = (i == 1) || (i == 2);
         parallel_data_in = 4'b1111;
      end
      @(negedge clk);
      checks++;
      if (obs !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL ignored_idle: got %b expected %b", obs, 5'b00001);
      end
   endtask

   task automatic test_reset_abort();
      load = 1'b1;
      parallel_data_in = 4'b1110;
      @(negedge clk);
      load = 1'b0;
      checks++;
      if (obs !== 5'b11010) begin
         errors++;
         $display("[TB] FAIL abort_bit0: got %b expected %b", obs, 5'b11010);
      end
      @(negedge clk);
      checks++;
      if (obs !== 5'b11010) begin
         errors++;
         $display("[TB] FAIL abort_bit1: got %b expected %b", obs, 5'b11010);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (obs !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL abort_reset: got %b expected %b", obs, 5'b00001);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL abort_quiet%0d: got %b expected %b", i, obs, 5'b00001);
         end
      end
   endtask

   // Scenario sequence followed by the single summary line.
   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_ignored_load();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
